// File: rtl/kiwifs_open_sequencer.sv
// Kiwi filesystem open sequencer: streams a filename to the fileserver one byte per
// request using a four-phase req/ack handshake, then issues the final open/exists call.
module kiwifs_open_sequencer #(
    parameter int MAX_NAME_LEN = 255,
    parameter int ACK_TIMEOUT  = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    output logic               busy,
    input  logic               name_valid,
    input  logic [7:0]         name_data,
    input  logic               name_last,
    output logic               name_ready,
    output logic               done,
    output logic               result_ok,
    output logic [7:0]         result_fd,
    output logic [1:0]         result_err,
    output logic               perform_bevfs_op_req,
    output logic signed [3:0]  perform_bevfs_op_cmd,
    output logic signed [63:0] perform_bevfs_op_a2,
    input  logic               perform_bevfs_op_ack,
    input  logic signed [63:0] perform_bevfs_op_return,
    output logic [2:0]         dbg_state,
    output logic [1:0]         dbg_phase
);

    // Name stream: a byte transfers on any rising edge where name_valid and name_ready
    // are both 1; name_data/name_last must be stable while name_valid waits for ready.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RELEASE, S_NAME, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {PH_START, PH_CHAR, PH_FINAL} phase_t;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t             state;
    phase_t             phase;
    logic [1:0]         mode_q;
    logic [10:0]        byte_cnt;
    logic [10:0]        cnt_inc;
    logic               last_q;
    logic [TW-1:0]      timer;
    logic signed [63:0] ret_q;

    assign cnt_inc   = byte_cnt + 11'd1;
    assign dbg_state = state;
    assign dbg_phase = phase;

    function automatic logic signed [63:0] mk_a2(input logic [3:0] sub, input logic [7:0] ch);
        return $signed({44'd0, sub, 8'd0, ch});
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= S_IDLE;
            phase                <= PH_START;
            mode_q               <= 2'd0;
            byte_cnt             <= 11'd0;
            last_q               <= 1'b0;
            timer                <= '0;
            ret_q                <= 64'sd0;
            busy                 <= 1'b0;
            name_ready           <= 1'b0;
            done                 <= 1'b0;
            result_ok            <= 1'b0;
            result_fd            <= 8'd0;
            result_err           <= 2'd0;
            perform_bevfs_op_req <= 1'b0;
            perform_bevfs_op_cmd <= 4'sd0;
            perform_bevfs_op_a2  <= 64'sd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && mode != 2'd0 && !perform_bevfs_op_ack) begin
                        mode_q               <= mode;
                        busy                 <= 1'b1;
                        byte_cnt             <= 11'd0;
                        result_ok            <= 1'b0;
                        result_fd            <= 8'd0;
                        result_err           <= 2'd0;
                        perform_bevfs_op_cmd <= 4'sd1;
                        perform_bevfs_op_a2  <= mk_a2(4'd1, 8'd0);
                        perform_bevfs_op_req <= 1'b1;
                        timer                <= TW'(ACK_TIMEOUT - 1);
                        phase                <= PH_START;
                        state                <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (perform_bevfs_op_ack) begin
                        ret_q                <= perform_bevfs_op_return;
                        perform_bevfs_op_req <= 1'b0;
                        state                <= S_RELEASE;
                    end else if (timer == '0) begin
                        perform_bevfs_op_req <= 1'b0;
                        result_ok            <= 1'b0;
                        result_fd            <= 8'd0;
                        result_err           <= 2'd3;
                        done                 <= 1'b1;
                        state                <= S_DONE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!perform_bevfs_op_ack) begin
                        case (phase)
                            PH_START: begin
                                name_ready <= 1'b1;
                                state      <= S_NAME;
                            end
                            PH_CHAR: begin
                                if (last_q) begin
                                    // Final subcode: 3=open-read, 4=open-write, 5=exists.
                                    perform_bevfs_op_a2  <= mk_a2({2'b00, mode_q} + 4'd2, 8'd0);
                                    perform_bevfs_op_req <= 1'b1;
                                    timer                <= TW'(ACK_TIMEOUT - 1);
                                    phase                <= PH_FINAL;
                                    state                <= S_ISSUE;
                                end else begin
                                    name_ready <= 1'b1;
                                    state      <= S_NAME;
                                end
                            end
                            default: begin
                                if (mode_q == 2'd3) begin
                                    result_ok  <= (ret_q != 64'sd0);
                                    result_fd  <= 8'd0;
                                    result_err <= 2'd0;
                                end else if (ret_q == 64'sd1) begin
                                    result_ok  <= 1'b0;
                                    result_fd  <= 8'd0;
                                    result_err <= 2'd1;
                                end else begin
                                    result_ok  <= 1'b1;
                                    result_fd  <= ret_q[63:56];
                                    result_err <= 2'd0;
                                end
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_NAME: begin
                    if (name_valid && name_ready) begin
                        last_q   <= name_last;
                        byte_cnt <= cnt_inc;
                        if (cnt_inc > 11'(MAX_NAME_LEN)) begin
                            result_err <= 2'd2;
                            if (name_last) begin
                                name_ready <= 1'b0;
                                done       <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            name_ready           <= 1'b0;
                            perform_bevfs_op_a2  <= mk_a2(4'd2, name_data);
                            perform_bevfs_op_req <= 1'b1;
                            timer                <= TW'(ACK_TIMEOUT - 1);
                            phase                <= PH_CHAR;
                            state                <= S_ISSUE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (name_valid && name_last) begin
                        name_ready <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                default: begin
                    busy                 <= 1'b0;
                    perform_bevfs_op_cmd <= 4'sd0;
                    perform_bevfs_op_a2  <= 64'sd0;
                    phase                <= PH_START;
                    state                <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/kiwifs_open_sequencer.md
KIWIFS_OPEN_SEQUENCER -- requirements
Module: kiwifs_open_sequencer

Interface
REQ-001 SHALL have parameter MAX_NAME_LEN, default 255: maximum accepted filename length in bytes.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1023: number of cycles to wait for a server ack before aborting.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin an open sequence.
REQ-006 SHALL have port mode, input, 2 bits: 1=open-read, 2=open-write, 3=exists-check, 0=invalid.
REQ-007 SHALL have port busy, output, 1 bit: high from start acceptance through the done cycle.
REQ-008 SHALL have filename byte-stream ports name_valid (in, 1), name_data (in, 8), name_last (in, 1) and name_ready (out, 1).
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port result_ok, output, 1 bit: success flag, or file-exists flag in mode 3.
REQ-011 SHALL have port result_fd, output, 8 bits: the Kiwi fd; 0 unless a mode 1/2 open succeeded.
REQ-012 SHALL have port result_err, output, 2 bits: 0=none, 1=server open fail, 2=name too long, 3=ack timeout.
REQ-013 SHALL have fileserver-side ports perform_bevfs_op_req (out, 1), perform_bevfs_op_cmd (out, 4 signed), perform_bevfs_op_a2 (out, 64 signed), perform_bevfs_op_ack (in, 1) and perform_bevfs_op_return (in, 64 signed).

Function
REQ-014 SHALL drive every server-side output from a register; cmd SHALL be 1 (open) while busy, and cmd and a2 SHALL be 0 while idle.
REQ-015 SHALL place the open subcode in a2[19:16] and the filename character in a2[7:0]; all other a2 bits SHALL be 0.
REQ-016 SHALL use a four-phase handshake on the server side:
- ISSUE: req=1 with cmd and a2 stable, held until ack=1.
- On the ack=1 cycle, perform_bevfs_op_return SHALL be captured and req SHALL fall on the next edge.
- RELEASE: req=0 until ack=0; the next request SHALL be issued no earlier than the cycle after ack=0 is seen.
REQ-017 SHALL use FSM states IDLE, ISSUE, RELEASE, NAME, DRAIN and DONE, plus a phase register holding START, CHAR or FINAL.
REQ-018 In IDLE, SHALL accept start only when mode!=0 and ack=0; on acceptance it SHALL latch mode, set busy, clear the byte count, and enter ISSUE/START with subcode 1.
REQ-019 In IDLE, SHALL ignore start when mode=0 or ack=1; no outputs SHALL change.
REQ-020 While busy, SHALL ignore start.
REQ-021 After RELEASE/START, SHALL enter NAME with name_ready=1; name_ready SHALL be 0 in every other state except DRAIN.
REQ-022 In NAME, on name_valid&name_ready, SHALL latch the byte and name_last, increment an 11-bit byte count, and enter ISSUE/CHAR with subcode 2.
REQ-023 After RELEASE/CHAR, SHALL return to NAME if the latched last flag is 0; if it is 1, SHALL enter ISSUE/FINAL with subcode 3, 4 or 5 for mode 1, 2 or 3 respectively.
REQ-024 If an accepted byte makes the count exceed MAX_NAME_LEN, SHALL issue no request for that byte, set err=2, and enter DRAIN.
REQ-025 In DRAIN, SHALL hold name_ready=1 and discard bytes until name_last is accepted, then enter DONE; a byte accepted with name_last=1 SHALL go straight to DONE.
REQ-026 At the end of FINAL for modes 1/2, if the captured return equals 1: ok=0, fd=0, err=1; otherwise: ok=1, fd=return[63:56], err=0.
REQ-027 At the end of FINAL for mode 3, SHALL set ok=(return!=0), fd=0, err=0.
REQ-028 SHALL reload a cycle counter on every ISSUE entry; if ACK_TIMEOUT cycles elapse in ISSUE with ack=0, it SHALL drop req, set err=3, ok=0, fd=0, and enter DONE.
REQ-029 In DONE, SHALL pulse done for exactly one cycle with result outputs valid, then return to IDLE and clear busy.
REQ-030 result_ok, result_fd and result_err SHALL hold their values until the next accepted start, which SHALL clear them.
REQ-031 End-to-end latency with a 1-cycle-ack server and always-valid bytes SHALL be 4 cycles per request (ISSUE, ack, RELEASE, ack-low) plus 1 NAME cycle per byte, plus 1 DONE cycle.

Reset
REQ-032 On reset=0, SHALL asynchronously enter IDLE and set req, cmd, a2, busy, name_ready, done, result_ok, result_fd and result_err to 0.
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; after release, a new start SHALL still wait for ack=0.

Verification
REQ-034 Mode 1, name "ab", server returns 0x0500_0000_0000_0000 on FINAL -> server sees a2 subcodes 1, 2/0x61, 2/0x62, 3; done with ok=1, fd=5, err=0.
REQ-035 Mode 2, server returns 1 on FINAL -> FINAL uses subcode 4; done with ok=0, fd=0, err=1.
REQ-036 Mode 3, server returns 0 on FINAL -> FINAL uses subcode 5; done with ok=0, fd=0, err=0.
REQ-037 MAX_NAME_LEN=4, 6-byte name -> exactly 4 CHAR requests, bytes 5-6 drained, no FINAL request; err=2.
REQ-038 ACK_TIMEOUT=8, server never acks START -> req falls after 8 cycles; done with err=3; a start with ack=1 held is ignored.
REQ-039 Reset asserted during CHAR ISSUE -> req=0 immediately, no done pulse, and all outputs are 0.
